// File: rtl/pipe_gen.sv
// Purpose: column-stream generator for the pipe shift register (slot words + shift strobes, LFSR gaps).
// Latency: registered outputs; a strobe appears the cycle after the frame_tick that wraps a column.
// Backpressure: none; the shift register always accepts a strobe.
module pipe_gen #(
    parameter int          SCROLL_PX      = 2,
    parameter int          COL_PX         = 60,
    parameter int          SLOTS_PER_PIPE = 5,
    parameter int          GAP_MIN        = 40,
    parameter int          GAP_MAX        = 350,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          FLUSH_SLOTS    = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_tick,
    input  logic        run,
    output logic [15:0] nxt_pipe,
    output logic        shift_en,
    output logic [5:0]  scroll_off,
    output logic        busy
);

    localparam int SW = (SLOTS_PER_PIPE > 1) ? $clog2(SLOTS_PER_PIPE) : 1;
    localparam int FW = $clog2(FLUSH_SLOTS + 1);

    localparam logic [15:0]   SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [6:0]    COL7       = 7'(COL_PX);
    localparam logic [6:0]    SCR7       = 7'(SCROLL_PX);
    localparam logic [15:0]   GMIN       = 16'(GAP_MIN);
    localparam logic [15:0]   GRANGE     = 16'(GAP_MAX - GAP_MIN + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS_PER_PIPE - 1);
    localparam logic [FW-1:0] FLUSH_DONE = FW'(FLUSH_SLOTS);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

    state_t          state_q, state_d;
    logic            run_q;
    logic [FW-1:0]   flush_q, flush_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [5:0]      scroll_q, scroll_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     pipe_q, pipe_d;
    logic            shift_q, shift_d;
    logic            busy_q, busy_d;
    logic [6:0]      s_sum, s_wrap;

    // Fold the low 9 LFSR bits into [GAP_MIN, GAP_MAX]; one subtraction suffices because the range is >= 256.
    function automatic logic [15:0] gap_of(input logic [15:0] l);
        logic [15:0] c;
        c = {7'd0, l[8:0]};
        if (c < GRANGE) return GMIN + c;
        else            return GMIN + c - GRANGE;
    endfunction

    // Galois right-shift step; taps 0xB400 give a maximal sequence that never hits zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign s_sum  = {1'b0, scroll_q} + SCR7;
    assign s_wrap = s_sum - COL7;

    // Next-state and registered-output logic for IDLE/FLUSH/RUN.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        slot_d   = slot_q;
        scroll_d = scroll_q;
        lfsr_d   = lfsr_q;
        pipe_d   = 16'd0;
        shift_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                scroll_d = 6'd0;
                slot_d   = '0;
                if (run && !run_q) begin
                    // First empty slot goes out on entry; flush_cnt counts strobes issued.
                    state_d = FLUSH;
                    flush_d = FW'(1);
                    shift_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FLUSH: begin
                scroll_d = 6'd0;
                slot_d   = '0;
                if (!run) begin
                    state_d = IDLE;
                end else if (flush_q == FLUSH_DONE) begin
                    state_d = RUN;
                end else begin
                    flush_d = flush_q + FW'(1);
                    shift_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    // LFSR is kept so the next game gets a different pipe sequence.
                    state_d  = IDLE;
                    scroll_d = 6'd0;
                    slot_d   = '0;
                end else if (frame_tick) begin
                    if (s_sum >= COL7) begin
                        scroll_d = s_wrap[5:0];
                        shift_d  = 1'b1;
                        if (slot_q == '0) begin
                            pipe_d = gap_of(lfsr_q);
                            lfsr_d = lfsr_step(lfsr_q);
                        end
                        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
                    end else begin
                        scroll_d = s_sum[5:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, LFSR and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            flush_q  <= '0;
            slot_q   <= '0;
            scroll_q <= 6'd0;
            lfsr_q   <= SEED_EFF;
            pipe_q   <= 16'd0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run;
            flush_q  <= flush_d;
            slot_q   <= slot_d;
            scroll_q <= scroll_d;
            lfsr_q   <= lfsr_d;
            pipe_q   <= pipe_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
        end
    end

    assign nxt_pipe   = pipe_q;
    assign shift_en   = shift_q;
    assign scroll_off = scroll_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Purpose: directed self-checking bench for pipe_gen (default seed plus a fold-range seed instance).
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: not applicable.
module tb_pipe_gen;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        frame_tick;
    logic        run;

    logic [15:0] a_pipe, b_pipe;
    logic        a_shift, b_shift;
    logic [5:0]  a_scroll, b_scroll;
    logic        a_busy, b_busy;

    int vecs = 0;
    int miss = 0;

    int last_a;
    int last_b;
    int last_bs;

    always #5 clk = ~clk;

    pipe_gen dut_a (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_tick (frame_tick),
        .run        (run),
        .nxt_pipe   (a_pipe),
        .shift_en   (a_shift),
        .scroll_off (a_scroll),
        .busy       (a_busy)
    );

    pipe_gen #(.SEED(16'h0190)) dut_b (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_tick (frame_tick),
        .run        (run),
        .nxt_pipe   (b_pipe),
        .shift_en   (b_shift),
        .scroll_off (b_scroll),
        .busy       (b_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        if (obs != exp) begin
            miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One frame tick at position t since the last flush; strobe expected every 30th tick.
    task automatic frame(input int t);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("scroll", a_scroll, (2 * t) % 60);
        check("strobe", a_shift, (t % 30 == 0) ? 1 : 0);
        last_a  = a_pipe;
        last_b  = b_pipe;
        last_bs = b_shift;
        @(negedge clk);
        check("strobe width", a_shift, 0);
    endtask

    // Raise run and expect 8 consecutive empty strobes with busy tracking them.
    task automatic do_flush();
        int first, last, cnt, bcnt;
        first = -1; last = -1; cnt = 0; bcnt = 0;
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_shift) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
                check("flush pipe", a_pipe, 0);
            end
            if (b_shift) bcnt++;
            check("flush busy", a_busy, a_shift);
        end
        check("flush count", cnt, 8);
        check("flush first", first, 0);
        check("flush last", last, 7);
        check("fold flush count", bcnt, 8);
        check("flush busy end", a_busy, 0);
        check("fold busy end", b_busy, 0);
        check("flush scroll", a_scroll, 0);
        check("fold scroll", b_scroll, 0);
    endtask

    initial begin
        n_rst      = 1'b0;
        run        = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst shift", a_shift, 0);
        check("rst pipe", a_pipe, 0);
        check("rst scroll", a_scroll, 0);
        check("rst busy", a_busy, 0);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle shift", a_shift, 0);

        // First game: pipes at ticks 30 and 180, empty slots between.
        do_flush();
        for (int t = 1; t <= 180; t++) begin
            frame(t);
            if (t % 30 == 0) begin
                check("pipe", last_a, (t == 30) ? 265 : (t == 180) ? 152 : 0);
                check("fold pipe", last_b, (t == 30) ? 129 : (t == 180) ? 240 : 0);
                check("fold strobe", last_bs, 1);
            end
        end

        // run drops on the wrapping tick: no strobe, back to IDLE.
        for (int t = 1; t <= 29; t++) frame(t);
        run        = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("stop strobe", a_shift, 0);
        check("stop scroll", a_scroll, 0);
        check("stop busy", a_busy, 0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("idle tick scroll", a_scroll, 0);
        check("idle tick strobe", a_shift, 0);

        // Second game continues from the retained LFSR (0x7138 -> c=312 folds to 41).
        do_flush();
        for (int t = 1; t <= 30; t++) frame(t);
        check("retained pipe", last_a, 41);
        check("retained fold pipe", last_b, 140);

        // Reset during flush after three strobes, then a fresh flush with run held high.
        run = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("pre-reset strobe", a_shift, 1);
        #2 n_rst = 1'b0;
        #1;
        check("async shift", a_shift, 0);
        check("async busy", a_busy, 0);
        check("async pipe", a_pipe, 0);
        check("async scroll", a_scroll, 0);
        @(negedge clk);
        n_rst = 1'b1;
        do_flush();
        for (int t = 1; t <= 30; t++) frame(t);
        check("seed pipe after reset", last_a, 265);
        check("fold seed pipe after reset", last_b, 129);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/pipe_gen.md
Name: pipe_gen

Overview:
- Produces the column stream that feeds the pipe shift register: one 16-bit slot word plus a one-cycle shift strobe each time the playfield scrolls one column.
- Slot word = pipe gap lower edge (y, pixels), or 0 for an empty column.
- Gap heights come from a 16-bit LFSR, folded into a legal range.
- On game start it flushes the 8-slot shift register with empty columns.

Parameters:
- SCROLL_PX, 2: pixels scrolled per frame_tick.
- COL_PX, 60: pixels per column slot (= pipe width).
- SLOTS_PER_PIPE, 5: slot period between pipes (60 pipe + 240 space = 5 slots).
- GAP_MIN, 40: minimum gap lower edge.
- GAP_MAX, 350: maximum gap lower edge; GAP_MAX-GAP_MIN+1 must lie in [256,512].
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- FLUSH_SLOTS, 8: empty slots emitted on game start.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- run  in  1  game active level
- nxt_pipe  out  16  slot word to shift register; valid while shift_en=1
- shift_en  out  1  one-cycle shift strobe (drives shift register en)
- scroll_off  out  6  sub-column scroll offset, 0..COL_PX-1, for the renderer
- busy  out  1  high during FLUSH

Behaviour:
- Reset (n_rst=0, async):
  - state=IDLE, nxt_pipe=0, shift_en=0, scroll_off=0, busy=0.
  - slot_cnt=0, flush_cnt=0, lfsr=SEED.
- All outputs are registered.
- States:
  - IDLE: outputs idle (shift_en=0, nxt_pipe=0). Rising edge of run (registered run_d=0, run=1) -> FLUSH with flush_cnt=0.
  - FLUSH: busy=1. Every cycle: shift_en=1, nxt_pipe=0, flush_cnt++. After FLUSH_SLOTS strobes (8 consecutive cycles) -> RUN, with busy=0 in the same cycle as the last strobe clears. frame_tick is ignored. slot_cnt and scroll_off are cleared.
  - RUN: on each frame_tick, s = scroll_off + SCROLL_PX.
    - If s >= COL_PX: scroll_off <= s - COL_PX, and the next cycle shift_en=1 for exactly one cycle.
      - If slot_cnt==0: nxt_pipe=gap(lfsr), then lfsr advances one step.
      - Otherwise nxt_pipe=0.
      - slot_cnt <= (slot_cnt==SLOTS_PER_PIPE-1) ? 0 : slot_cnt+1.
    - Otherwise scroll_off <= s, with no strobe.
  - run=0 in FLUSH or RUN -> IDLE the next cycle, with no further strobes. scroll_off and slot_cnt clear; lfsr is retained so the next game differs.
- LFSR: Galois, right shift. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only on pipe emission and never reaches 0.
- gap(lfsr): c = lfsr[8:0].
  - gap = GAP_MIN + c if c <= GAP_MAX-GAP_MIN.
  - Otherwise gap = GAP_MIN + c - (GAP_MAX-GAP_MIN+1).
  - Result is always in [GAP_MIN, GAP_MAX] and never 0.
- Widths: scroll arithmetic is 7-bit unsigned (no overflow, since COL_PX+SCROLL_PX < 128). gap arithmetic is 16-bit unsigned.
- Simultaneous events:
  - frame_tick together with run falling -> no strobe.
  - frame_tick in the same cycle as the FLUSH->RUN transition -> ignored.
  - run rising in the same cycle as the reset release -> the edge is detected on the first clock after reset.
- Reset mid-FLUSH/RUN: immediate return to reset values. A strobe cut short by reset is not reissued.

Test Plan:
- Reset, then run=1 -> busy=1 and shift_en=1 for exactly 8 consecutive cycles with nxt_pipe=0; then busy=0 and state RUN; scroll_off=0.
- After flush, 30 frame_ticks (SEED=ACE1) -> a single shift_en on the cycle after tick 30, with nxt_pipe=265 (c=225); scroll_off=0.
- Continue to ticks 60, 90, 120, 150 -> strobes with nxt_pipe=0. Tick 180 -> nxt_pipe=152 (lfsr=E270, c=112). No strobes on other ticks. scroll_off steps 0,2,...,58,0.
- Fold check: force lfsr low bits with c=400 (e.g. seed 16'h0190) -> gap = 40+400-311 = 129.
- run=0 coincident with tick 30 -> no strobe; state IDLE; scroll_off=0. run=1 again -> 8-cycle flush; next pipe uses the retained (advanced) lfsr value, not SEED.
- n_rst low mid-FLUSH (after 3 strobes) -> outputs 0 asynchronously. After release with run held 1, a fresh flush of 8 strobes runs.
